blockade_vram_arbiter: RTL
==========================

# blockade_vram_arbiter

Single-port video RAM arbiter for the Blockade/CoMotion/Hustle/Blasto core. Shares one synchronous 1K x 8 RAM between the video fetch (fixed slot on every `ce_vid` strobe) and the 8080 CPU (request/acknowledge handshake serviced in the free cycles between video slots). It replaces the dual-port VRAM arrangement and can optionally restrict CPU writes to vertical blank, matching the original board.

## Interface
- `ADDR_WIDTH`, 10: VRAM address width.
- `DATA_WIDTH`, 8: VRAM data width.
- `WAIT_WIDTH`, 16: width of the CPU wait-cycle counter and the `last_wait` output; the counter saturates.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `ce_vid` in 1: video slot strobe, one cycle in every 4.
- `vblank` in 1: high during vertical blank.
- `vid_addr` in ADDR_WIDTH: video fetch address, sampled when `ce_vid` is high.
- `vid_data` out DATA_WIDTH: registered video fetch result, held until the next fetch completes.
- `cpu_req` in 1: CPU access request (level), held until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr` in ADDR_WIDTH: CPU address; stable while `cpu_req` is high.
- `cpu_wdata` in DATA_WIDTH: CPU write data; stable while `cpu_req` is high.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out DATA_WIDTH: read data, valid with `cpu_ack` and held afterwards.
- `ram_addr` out ADDR_WIDTH: RAM address (combinational from grant).
- `ram_we` out 1: RAM write enable (combinational from grant).
- `ram_wdata` out DATA_WIDTH: RAM write data (`cpu_wdata`).
- `ram_q` in DATA_WIDTH: RAM read data, one-cycle registered read latency.
- `last_wait` out WAIT_WIDTH: number of cycles between request and grant for the most recently acknowledged CPU access.

## Operation
- Grant per cycle, decided combinationally:
  - If `ce_vid` is high: video grant; `ram_addr` = `vid_addr`, `ram_we` = 0.
  - Otherwise, if a CPU request is eligible: CPU grant; `ram_addr` = `cpu_addr`, `ram_we` = `cpu_we`.
  - Otherwise: idle; `ram_addr` = `vid_addr`, `ram_we` = 0.
- A CPU request is eligible when `cpu_req` is high, the state is IDLE, and the write gating permits it (see Configuration).
- CPU FSM states:
  - IDLE: a CPU grant moves to ACK.
  - ACK: assert `cpu_ack`; if the granted access was a read, load `cpu_rdata` from `ram_q`; return to IDLE.
  - `cpu_req` is ignored in ACK, so the same request cannot be serviced twice.
- Video pipeline: a flag registered from `ce_vid` loads `vid_data` from `ram_q` one cycle after the video grant. This path is independent of the CPU FSM.
- Wait counter:
  - Cleared on a CPU grant.
  - Increments, saturating, each cycle `cpu_req` is high in IDLE without a grant.
  - Copied to `last_wait` on the grant cycle.
- Video always wins a collision with the CPU; the CPU is never granted on a `ce_vid` cycle.
- Reset mid-operation: the FSM returns to IDLE, any pending ACK is dropped with no `cpu_ack`, and the wait counter clears.
- Reset values: `vid_data` = 0, `cpu_ack` = 0, `cpu_rdata` = 0, `last_wait` = 0.

## Timing
- Video: `ce_vid` at cycle t → `vid_data` updated at the end of t+1, visible from t+2. Fixed latency of 2, never stalled.
- CPU, no conflict: `cpu_req` rises at t → grant at t → `cpu_ack` at t+1 (read data valid at t+1).
- CPU, `ce_vid` at t: grant at t+1, `cpu_ack` at t+2. Maximum deferral outside write gating is 1 cycle.
- Back-to-back CPU accesses: the next grant comes no earlier than the cycle after `cpu_ack`. Peak rate is one access per 2 cycles.
- `ce_vid` during the ACK cycle is legal; the video and CPU capture paths do not interfere.
- `ram_we` is asserted for exactly one cycle per CPU write.

## Configuration
- `BLOCKADE_VRAM_VBLANK_WRITE_EN`
  - Defined: CPU writes are eligible only while `vblank` = 1. A write requested during active display waits until `vblank` rises, and `last_wait` reflects the full stall. Reads are unaffected.
  - Undefined: reads and writes are eligible in any non-`ce_vid` cycle.

## Test plan
- Reset, then `ce_vid` every 4 cycles with RAM preloaded so address N holds N[7:0]; `vid_addr` = 0x155 → `vid_data` = 0x55 two cycles after the strobe, held for 4 cycles, no `cpu_ack`.
- CPU write 0xA5 to 0x3FF, then read 0x3FF, both in non-`ce_vid` cycles → each `cpu_ack` one cycle after its request, `cpu_rdata` = 0xA5, `last_wait` = 0.
- `cpu_req` read raised on the same cycle as `ce_vid` → `ram_addr` = `vid_addr` that cycle, CPU grant next cycle, `cpu_ack` 2 cycles after the request, `last_wait` = 1.
- With the macro defined, `vblank` = 0, write requested, `vblank` rises 100 cycles later → `ram_we` first high in the first non-`ce_vid` cycle of vblank, `last_wait` ≥ 100; without the macro, `cpu_ack` within 2 cycles.
- `reset` pulsed in the cycle after a CPU grant → no `cpu_ack`, `cpu_rdata` = 0, `last_wait` = 0; a new request afterwards completes normally.
- `cpu_req` held high for 20 cycles with `ce_vid` running → exactly one `ram_we` pulse per `cpu_ack`, acks never closer than 2 cycles apart, none coincide with a video grant.

Source files
------------

// File: rtl/blockade_vram_arbiter.sv
// Single-port 1K x 8 VRAM arbiter: fixed video slot on ce_vid, CPU req/ack in the gaps.
// Optional feature macro: BLOCKADE_VRAM_VBLANK_WRITE_EN restricts CPU writes to vertical blank.
module blockade_vram_arbiter #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned WAIT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce_vid,
   input  logic                  vblank,
   input  logic [ADDR_WIDTH-1:0] vid_addr,
   output logic [DATA_WIDTH-1:0] vid_data,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_ack,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic [WAIT_WIDTH-1:0] last_wait
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACK  = 1'b1;
   localparam logic [WAIT_WIDTH-1:0] WAIT_MAX = '1;

   logic [0:0]            state_q, state_d;
   logic                  wr_q, wr_d;
   logic                  vid_fetch_q;
   logic [DATA_WIDTH-1:0] vid_data_q;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [WAIT_WIDTH-1:0] wait_q, wait_d;
   logic [WAIT_WIDTH-1:0] last_wait_q, last_wait_d;
   logic                  wr_ok_c;
   logic                  cpu_grant_c;

`ifdef BLOCKADE_VRAM_VBLANK_WRITE_EN
   assign wr_ok_c = ~cpu_we | vblank;
`else
   assign wr_ok_c = 1'b1;
`endif

   // Video always wins the slot; the CPU only takes free cycles while IDLE
   assign cpu_grant_c = ~ce_vid & cpu_req & (state_q == ST_IDLE) & wr_ok_c;

   assign ram_addr  = cpu_grant_c ? cpu_addr : vid_addr;
   assign ram_we    = cpu_grant_c & cpu_we;
   assign ram_wdata = cpu_wdata;

   // Ack is masked by reset so a pending acknowledge is dropped, not delivered
   assign cpu_ack   = (state_q == ST_ACK) & ~reset;
   assign cpu_rdata = (cpu_ack & ~wr_q) ? ram_q : rdata_q;
   assign vid_data  = vid_data_q;
   assign last_wait = last_wait_q;

   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      rdata_d     = rdata_q;
      wait_d      = wait_q;
      last_wait_d = last_wait_q;
      case (state_q)
         ST_IDLE: begin
            if (cpu_grant_c) begin
               state_d     = ST_ACK;
               wr_d        = cpu_we;
               wait_d      = '0;
               last_wait_d = wait_q;
            end else if (cpu_req && (wait_q != WAIT_MAX)) begin
               wait_d = wait_q + WAIT_WIDTH'(1);
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
            if (!wr_q) rdata_d = ram_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wr_q        <= 1'b0;
         rdata_q     <= '0;
         wait_q      <= '0;
         last_wait_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         rdata_q     <= rdata_d;
         wait_q      <= wait_d;
         last_wait_q <= last_wait_d;
      end
   end

   // Video capture: ram_q carries the fetch one cycle after the video grant
   always_ff @(posedge clk) begin
      if (reset) begin
         vid_fetch_q <= 1'b0;
         vid_data_q  <= '0;
      end else begin
         vid_fetch_q <= ce_vid;
         if (vid_fetch_q) vid_data_q <= ram_q;
      end
   end

endmodule
